// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the counter sequencer.
package cnt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } cnt_seq_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/cnt_tick_gen.sv
// Free-running step-rate divider: tick is high on the last count of every
// TICK_DIV-cycle period. Held at zero while clr is high so each run starts
// with a full period.
module cnt_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] presc_reg;

    assign tick = (presc_reg == LAST);

    // Prescaler: clear, wrap on the last count, otherwise increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (clr || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + CW'(1);
        end
    end

endmodule

// File: rtl/up_dn_counter.sv
// Loadable up/down counter driven by the sequencer; load has priority over
// enable, and counting wraps modulo 2^WIDTH.
module up_dn_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    assign count = count_reg;

    // Count register: load, else step in the requested direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= count_in;
        end else if (en) begin
            count_reg <= up ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1);
        end
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command-driven sequencer for a loadable up/down counter.
// Accepts {start, end, up}, loads the counter, steps it every TICK_DIV
// cycles until it shows the end value, then pulses done.
// Optional lap-repeat mode is enabled with the macro CNT_SEQ_CTRL_REPEAT_EN.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             cmd_up,
`ifdef CNT_SEQ_CTRL_REPEAT_EN
    input  logic             cmd_repeat,
`endif
    input  logic             abort,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             busy,
    output logic             done
);

    cnt_seq_state_t   state_reg, state_next;
    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] end_reg;
    logic             dir_reg;
    logic             repeat_reg;
    logic             accept;
    logic             abort_act;
    logic             tick;

    assign accept    = cmd_valid && (state_reg == IDLE);
    // Abort only matters while a sequence is loading or running.
    assign abort_act = abort && ((state_reg == LOAD) || (state_reg == RUN));

    cnt_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_reg != RUN),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command latch, captured on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_reg <= '0;
            end_reg   <= '0;
            dir_reg   <= DIR_DN;
        end else if (accept) begin
            start_reg <= cmd_start;
            end_reg   <= cmd_end;
            dir_reg   <= cmd_up ? DIR_UP : DIR_DN;
        end
    end

`ifdef CNT_SEQ_CTRL_REPEAT_EN
    // Repeat flag: set at acceptance, dropped by abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeat_reg <= 1'b0;
        end else if (accept) begin
            repeat_reg <= cmd_repeat;
        end else if (abort_act) begin
            repeat_reg <= 1'b0;
        end
    end
`else
    assign repeat_reg = 1'b0;
`endif

    // Next-state and output decode; abort gates load/enable in the same cycle.
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        cnt_en     = 1'b0;
        cnt_up     = 1'b0;
        cnt_load   = 1'b0;
        cnt_in     = '0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cnt_up = dir_reg;
                cnt_in = start_reg;
                if (abort_act) begin
                    state_next = IDLE;
                end else begin
                    cnt_load   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                cnt_up = dir_reg;
                if (abort_act) begin
                    state_next = IDLE;
                end else if (cnt_val == end_reg) begin
                    state_next = DONE;
                end else begin
                    cnt_en = tick;
                end
            end
            DONE: begin
                cnt_up     = dir_reg;
                done       = 1'b1;
                state_next = repeat_reg ? LOAD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
